// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - function codes, FSM states and flag indices for the sequential ALU
package seq_alu_pkg;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_AND  = 4'd2,
        FN_OR   = 4'd3,
        FN_XOR  = 4'd4,
        FN_NOT  = 4'd5,
        FN_SHL  = 4'd6,
        FN_SHR  = 4'd7,
        FN_ASR  = 4'd8,
        FN_INC  = 4'd9,
        FN_DEC  = 4'd10,
        FN_PASS = 4'd11,
        FN_MUL  = 4'd12,
        FN_DIV  = 4'd13,
        FN_REM  = 4'd14,
        FN_CMP  = 4'd15
    } alu_fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic logic is_multi(input alu_fn_e f);
        return (f == FN_MUL) || (f == FN_DIV) || (f == FN_REM);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - iterative shift-add multiplier / restoring divider, one step per cycle
module seq_alu_iter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             hi_nz,
    output logic             dbz,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    // hi/lo double as product halves (MUL) or partial remainder/quotient (DIV)
    logic             running;
    logic             is_mul;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        if (is_mul) begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, opnd}) begin
            hi_nx = WIDTH'(div_shift - {1'b0, opnd});
            lo_nx = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nx = div_shift[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // Results are the post-step values so the caller can capture them on the last edge
    assign result    = lo_nx;
    assign remainder = hi_nx;
    assign hi_nz     = |hi_nx;
    assign dbz       = (opnd == '0);
    assign last      = running && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            is_mul  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            is_mul  <= mode;
            hi      <= '0;
            lo      <= mode ? b : a;
            opnd    <= mode ? a : b;
            cnt     <= '0;
        end else if (running) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (last) running <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// rtl/seq_alu_core.sv - multi-cycle ALU: accumulator A, result G, flags and busy/done handshake
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int FN_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op,
    input  logic             ain,
    input  logic             gin,
    input  logic             gout,
    input  logic [FN_W-1:0]  fn,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int MSB = WIDTH - 1;

    state_e           state;
    alu_fn_e          fn_e;
    alu_fn_e          mc_fn;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic [3:0]       sc_flags;
    logic [WIDTH-1:0] mc_res;
    logic [3:0]       mc_flags;
    logic             it_start;
    logic [WIDTH-1:0] it_result;
    logic [WIDTH-1:0] it_rem;
    logic             it_hi_nz;
    logic             it_dbz;
    logic             it_last;

    assign fn_e = alu_fn_e'(fn[3:0]);

    // INC/DEC reuse the add/subtract paths with a constant second operand
    assign add_b   = (fn_e == FN_INC || fn_e == FN_DEC) ? WIDTH'(1) : op;
    assign add_sum = {1'b0, a_r} + {1'b0, add_b};
    assign sub_dif = {1'b0, a_r} - {1'b0, add_b};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (fn_e)
            FN_ADD, FN_INC: begin
                sc_res = add_sum[MSB:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (a_r[MSB] == add_b[MSB]) && (add_sum[MSB] != a_r[MSB]);
            end
            FN_SUB, FN_DEC, FN_CMP: begin
                sc_res = sub_dif[MSB:0];
                sc_c   = ~sub_dif[WIDTH];
                sc_v   = (a_r[MSB] != add_b[MSB]) && (sub_dif[MSB] != a_r[MSB]);
            end
            FN_AND:  sc_res = a_r & op;
            FN_OR:   sc_res = a_r | op;
            FN_XOR:  sc_res = a_r ^ op;
            FN_NOT:  sc_res = ~a_r;
            FN_SHL:  {sc_c, sc_res} = {a_r, 1'b0};
            FN_SHR:  {sc_res, sc_c} = {1'b0, a_r};
            FN_ASR:  {sc_res, sc_c} = {a_r[MSB], a_r};
            FN_PASS: sc_res = op;
            default: sc_res = '0;
        endcase
        sc_flags        = '0;
        sc_flags[FLG_Z] = (sc_res == '0);
        sc_flags[FLG_N] = sc_res[MSB];
        sc_flags[FLG_C] = sc_c;
        sc_flags[FLG_V] = sc_v;

        mc_res          = (mc_fn == FN_REM) ? it_rem : it_result;
        mc_flags        = '0;
        mc_flags[FLG_Z] = (mc_res == '0);
        mc_flags[FLG_N] = mc_res[MSB];
        mc_flags[FLG_V] = (mc_fn == FN_MUL) ? it_hi_nz : it_dbz;
    end

    assign it_start = (state == IDLE) && gin && is_multi(fn_e);

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (it_start),
        .a         (a_r),
        .b         (op),
        .mode      (fn_e == FN_MUL),
        .result    (it_result),
        .remainder (it_rem),
        .hi_nz     (it_hi_nz),
        .dbz       (it_dbz),
        .last      (it_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mc_fn <= FN_ADD;
            a_r   <= '0;
            g_r   <= '0;
            flags <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ain && state != DONE) a_r <= op;
            case (state)
                IDLE: begin
                    if (gin) begin
                        if (is_multi(fn_e)) begin
                            state <= CALC;
                            mc_fn <= fn_e;
                            busy  <= 1'b1;
                        end else begin
                            if (fn_e != FN_CMP) g_r <= sc_res;
                            flags <= sc_flags;
                            done  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (it_last) begin
                        g_r   <= mc_res;
                        flags <= mc_flags;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign res = gout ? g_r : '0;

endmodule
